irq_arbiter: RTL and testbench
==============================

IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, meaning number of interrupt sources (1..8).
REQ-002 Parameter HOLDOFF_W, default 16, meaning holdoff counter width.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 address  input  3  Avalon slave word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  registered read data.
REQ-010 irq_in  input  NUM_SRC  raw interrupt lines (G-sensor INT1/INT2, keys, etc.).
REQ-011 irq  output  1  single arbitrated interrupt to CPU.

Function
REQ-012 Register map: 0 RAW (RO, synchronized irq_in); 1 PENDING (read; write-1-to-clear); 2 MASK (RW); 3 VECTOR (RO: bit31 valid, bits[2:0] index); 4 ACK (WO, writedata[2:0] index); 5 HOLDOFF (RW, HOLDOFF_W bits); 6-7 read 0.
REQ-013 Read latency: readdata updates on the clk edge after address is presented, regardless of chipselect; unused bits 0.
REQ-014 Per source: two-stage capture d1<=irq_in, d2<=d1; rising edge = d1 & ~d2.
REQ-015 Edge sets PENDING bit on next clk; edge and W1C to same bit in same cycle: set wins.
REQ-016 FSM states IDLE, ASSERT, HOLDOFF; irq = (state==ASSERT), registered-state-derived, glitch-free.
REQ-017 IDLE: if (PENDING & MASK) != 0, latch lowest set index into VECTOR, set valid, go ASSERT next clk.
REQ-018 Latency: irq high 3 rising edges after the first edge sampling irq_in high (source unmasked, FSM IDLE).
REQ-019 ASSERT: ACK write with index == latched index clears that PENDING bit, clears valid, goes HOLDOFF.
REQ-020 ACK with mismatched index, or any ACK outside ASSERT: ignored, no state change.
REQ-021 ASSERT: if latched bit is cleared by W1C or masked, return to IDLE next clk, valid cleared, irq drops.
REQ-022 Edge on latched source while ASSERT: PENDING stays set; after ACK in same cycle, set wins and source re-arbitrates.
REQ-023 HOLDOFF: counter loaded with HOLDOFF value on entry, decrements each clk, exits to IDLE at 0; HOLDOFF=0 exits after one clk.
REQ-024 MASK/HOLDOFF writes take effect next clk; a HOLDOFF write does not disturb a running count.

Reset
REQ-025 On reset_n low: state IDLE, irq 0, readdata 0, PENDING/MASK/VECTOR/HOLDOFF/counter 0, d1/d2 0.
REQ-026 Reset mid-ASSERT or mid-HOLDOFF: pending events discarded; first edge after release is captured normally.

Configuration
REQ-027 Macro IRQ_ARBITER_COALESCE_EN defined: HOLDOFF state, counter and register 5 present per REQ-023.
REQ-028 Macro undefined: no HOLDOFF state or counter; accepted ACK goes directly to IDLE; register 5 reads 0, writes ignored.

Structure
REQ-029 Package irq_arbiter_pkg holds register address constants, FSM state enum, VECTOR valid-bit position.
REQ-030 Sub-module irq_edge_capture (one source: d1/d2 stages, edge pulse, synchronized level) instantiated NUM_SRC times via generate.

Verification
REQ-031 MASK=0xF, pulse irq_in[2] high -> irq high 3 clks later; VECTOR reads 0x80000002; ACK 2 -> irq low, PENDING[2]=0.
REQ-032 Edges on irq_in[1] and [3] same clk, MASK=0xF -> VECTOR index 1; ACK 1 -> irq re-asserts with index 3.
REQ-033 MASK=0x0, edge on irq_in[0] -> PENDING=0x1, irq stays 0; write MASK=0x1 -> irq high.
REQ-034 In ASSERT index 2, ACK 1 -> ignored, irq stays high; W1C PENDING=0x4 -> irq low next clk, valid 0.
REQ-035 COALESCE_EN, HOLDOFF=10, two sources pending -> after ACK, irq low exactly 11 clks then re-asserts; undefined -> 1 clk.
REQ-036 Assert reset_n mid-ASSERT -> irq, readdata, PENDING all 0 immediately; fresh edge after release -> normal 3-clk irq.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// Shared register map, FSM state encoding and priority helper for irq_arbiter.
// The HOLDOFF state only exists when IRQ_ARBITER_COALESCE_EN is defined.
package irq_arbiter_pkg;

  localparam logic [2:0] ADDR_RAW     = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_VECTOR  = 3'd3;
  localparam logic [2:0] ADDR_ACK     = 3'd4;
  localparam logic [2:0] ADDR_HOLDOFF = 3'd5;

  localparam int VEC_VALID_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1
`ifdef IRQ_ARBITER_COALESCE_EN
    , ST_HOLDOFF = 2'd2
`endif
  } state_e;

  // Lowest set bit wins, so source 0 has the highest priority.
  function automatic logic [2:0] lowestIdx(input logic [7:0] v);
    lowestIdx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowestIdx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/irq_edge_capture.sv
// Two-stage capture of one raw interrupt line; emits a one-clock rising-edge
// pulse and the synchronized level.
module irq_edge_capture (
  input  logic clk,
  input  logic reset_n,
  input  logic irq_i,
  output logic edge_o,
  output logic level_o
);

  logic d1_q, d2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1_q <= 1'b0;
      d2_q <= 1'b0;
    end else begin
      d1_q <= irq_i;
      d2_q <= d1_q;
    end
  end

  assign edge_o  = d1_q & ~d2_q;
  assign level_o = d2_q;

endmodule

// File: rtl/irq_arbiter.sv
// Avalon-MM interrupt arbiter: edge-captured PENDING, MASK, lowest-index VECTOR
// and ACK handshake. Define IRQ_ARBITER_COALESCE_EN for the post-ACK holdoff.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int HOLDOFF_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq
);

  logic [NUM_SRC-1:0] rise, level;
  logic [NUM_SRC-1:0] pending_q, pending_d, mask_q, mask_d;
  logic [NUM_SRC-1:0] selOh, ackClr, w1c, active;
  state_e             state_q, state_d;
  logic [2:0]         vecIdx_q, vecIdx_d;
  logic               vecValid_q, vecValid_d;
  logic [31:0]        readdata_q, rdMux;
  logic               wrEn, ackHit, latchedLive;
  logic               unused_wdata;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cap
    irq_edge_capture u_cap (
      .clk     (clk),
      .reset_n (reset_n),
      .irq_i   (irq_in[g]),
      .edge_o  (rise[g]),
      .level_o (level[g])
    );
  end

  assign wrEn         = chipselect & ~write_n;
  assign unused_wdata = &{1'b0, writedata};
  assign active       = pending_q & mask_q;
  assign ackHit       = wrEn && (address == ADDR_ACK) && (state_q == ST_ASSERT)
                        && (writedata[2:0] == vecIdx_q);

  // New edges are OR-ed in last so a capture beats a same-cycle clear.
  always_comb begin
    selOh = '0;
    for (int i = 0; i < NUM_SRC; i++) selOh[i] = (vecIdx_q == 3'(i));
    ackClr      = ackHit ? selOh : '0;
    w1c         = (wrEn && address == ADDR_PENDING) ? writedata[NUM_SRC-1:0] : '0;
    pending_d   = (pending_q & ~w1c & ~ackClr) | rise;
    mask_d      = (wrEn && address == ADDR_MASK) ? writedata[NUM_SRC-1:0] : mask_q;
    latchedLive = |(pending_d & mask_d & selOh);
  end

`ifdef IRQ_ARBITER_COALESCE_EN
  logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d, holdCnt_q, holdCnt_d;

  always_comb begin
    holdoff_d = (wrEn && address == ADDR_HOLDOFF) ? writedata[HOLDOFF_W-1:0] : holdoff_q;
    holdCnt_d = holdCnt_q;
    if (ackHit) holdCnt_d = holdoff_q;
    else if (state_q == ST_HOLDOFF && holdCnt_q != '0) holdCnt_d = holdCnt_q - HOLDOFF_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      holdoff_q <= '0;
      holdCnt_q <= '0;
    end else begin
      holdoff_q <= holdoff_d;
      holdCnt_q <= holdCnt_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      vecIdx_q   <= 3'd0;
      vecValid_q <= 1'b0;
      pending_q  <= '0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      vecIdx_q   <= vecIdx_d;
      vecValid_q <= vecValid_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
    end
  end

  // ASSERT looks at next-cycle PENDING/MASK so a W1C or mask-off drops irq at once.
  always_comb begin
    state_d    = state_q;
    vecIdx_d   = vecIdx_q;
    vecValid_d = vecValid_q;
    case (state_q)
      ST_IDLE: begin
        if (|active) begin
          state_d    = ST_ASSERT;
          vecIdx_d   = lowestIdx(8'(active));
          vecValid_d = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (ackHit) begin
          vecValid_d = 1'b0;
`ifdef IRQ_ARBITER_COALESCE_EN
          state_d    = ST_HOLDOFF;
`else
          state_d    = ST_IDLE;
`endif
        end else if (!latchedLive) begin
          vecValid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
`ifdef IRQ_ARBITER_COALESCE_EN
      // Leaving at a count of 1 gives exactly HOLDOFF cycles here (1 when HOLDOFF=0).
      ST_HOLDOFF: begin
        if (holdCnt_q <= HOLDOFF_W'(1)) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    irq = (state_q == ST_ASSERT);
  end

  always_comb begin
    rdMux = '0;
    case (address)
      ADDR_RAW:     rdMux[NUM_SRC-1:0] = level;
      ADDR_PENDING: rdMux[NUM_SRC-1:0] = pending_q;
      ADDR_MASK:    rdMux[NUM_SRC-1:0] = mask_q;
      ADDR_VECTOR: begin
        rdMux[VEC_VALID_BIT] = vecValid_q;
        rdMux[2:0]           = vecIdx_q;
      end
`ifdef IRQ_ARBITER_COALESCE_EN
      ADDR_HOLDOFF: rdMux[HOLDOFF_W-1:0] = holdoff_q;
`endif
      default:      rdMux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= rdMux;
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a behavioural model.
module tb_irq_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  irq_in;
  logic        irq;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  irq_arbiter #(.NUM_SRC(4), .HOLDOFF_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

`ifdef IRQ_ARBITER_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  typedef struct {
    logic [3:0]  irqIn;
    logic        cs;
    logic        wrN;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        expIrq;
    logic [31:0] expRd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t rdRow(input logic [3:0] i, input logic [2:0] a,
                                 input logic e, input logic [31:0] r);
    rdRow = '{i, 1'b0, 1'b1, a, 32'h0, e, r};
  endfunction

  function automatic vec_t wrRow(input logic [2:0] a, input logic [31:0] d,
                                 input logic e, input logic [31:0] r);
    wrRow = '{4'h0, 1'b1, 1'b0, a, d, e, r};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, sample 1ns later.
  task automatic applyStimulus(input logic [3:0] i, input logic cs, input logic wrN,
                               input logic [2:0] a, input logic [31:0] d);
    irq_in = i; chipselect = cs; write_n = wrN; address = a; writedata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(4'h0, 1'b0, 1'b1, 3'd0, 32'h0);
  endtask

  task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
    applyStimulus(4'h0, 1'b1, 1'b0, a, d);
  endtask

  task automatic busRead(input logic [2:0] a, output logic [31:0] d);
    applyStimulus(4'h0, 1'b0, 1'b1, a, 32'h0);
    d = readdata;
  endtask

  task automatic waitIrqHigh(input int bound, output int n);
    n = 0;
    while (irq !== 1'b1 && n < bound) begin
      idleCycle();
      n++;
    end
  endtask

  // Behavioural model: integers for registers, sample history for edges,
  // and a count of remaining quiet cycles after an accepted ACK.
  int mHist1, mHist2, mPend, mMask, mHreg, mIdx, mHoldLeft;
  bit mBusy, mVld;

  task automatic modelReset();
    mHist1 = 0; mHist2 = 0; mPend = 0; mMask = 0; mHreg = 0;
    mIdx = 0; mHoldLeft = 0; mBusy = 0; mVld = 0;
  endtask

  task automatic modelStep(input logic [3:0] i, input logic cs, input logic wrN,
                           input logic [2:0] a, input logic [31:0] d,
                           output logic eIrq, output logic [31:0] eRd);
    int rise, newPend, newMask, newHreg, act;
    bit we, ackOk;
    case (a)
      3'd0:    eRd = 32'(mHist2);
      3'd1:    eRd = 32'(mPend);
      3'd2:    eRd = 32'(mMask);
      3'd3:    eRd = (mVld ? 32'h8000_0000 : 32'h0) | 32'(mIdx);
      3'd5:    eRd = COALESCE ? 32'(mHreg) : 32'h0;
      default: eRd = 32'h0;
    endcase
    we      = cs && !wrN;
    rise    = mHist1 & ~mHist2 & 'hF;
    ackOk   = we && a == 3'd4 && mBusy && int'(d[2:0]) == mIdx;
    newPend = mPend;
    if (we && a == 3'd1) newPend = newPend & ~int'(d);
    if (ackOk) newPend = newPend & ~(1 << mIdx);
    newPend = (newPend | rise) & 'hF;
    newMask = (we && a == 3'd2) ? int'(d[3:0]) : mMask;
    newHreg = (COALESCE && we && a == 3'd5) ? int'(d[15:0]) : mHreg;
    act     = mPend & mMask;
    if (mBusy) begin
      if (ackOk) begin
        mBusy = 0; mVld = 0;
        mHoldLeft = COALESCE ? ((mHreg == 0) ? 1 : mHreg) : 0;
      end else if (((newPend & newMask) >> mIdx & 1) == 0) begin
        mBusy = 0; mVld = 0;
      end
    end else if (mHoldLeft > 0) begin
      mHoldLeft--;
    end else if (act != 0) begin
      for (int k = 3; k >= 0; k--) if (((act >> k) & 1) == 1) mIdx = k;
      mBusy = 1; mVld = 1;
    end
    mPend = newPend; mMask = newMask; mHreg = newHreg;
    mHist2 = mHist1; mHist1 = int'(i);
    eIrq = mBusy;
  endtask

  logic [31:0] rd;
  logic        eIrq;
  logic [31:0] eRd;
  int          n;
  logic [3:0]  irqR;
  logic        rCs, rWrN;
  logic [2:0]  rA;
  logic [31:0] rD;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; irq_in = '0; chipselect = 1'b0; write_n = 1'b1;
    address = '0; writedata = '0;
    #3;
    checkOutput("reset irq", {31'h0, irq}, 32'h0);
    checkOutput("reset readdata", readdata, 32'h0);
    #9 reset_n = 1'b1;

    // Single-source flow through masked pending, VECTOR, mismatched ACK and W1C.
    tbl.push_back(rdRow(4'h0, 3'd0, 1'b0, 32'h0));
    tbl.push_back(rdRow(4'h1, 3'd1, 1'b0, 32'h0));
    tbl.push_back(rdRow(4'h0, 3'd1, 1'b0, 32'h0));
    tbl.push_back(rdRow(4'h0, 3'd1, 1'b0, 32'h1));
    tbl.push_back(wrRow(3'd2, 32'h1, 1'b0, 32'h0));
    tbl.push_back(rdRow(4'h0, 3'd2, 1'b1, 32'h1));
    tbl.push_back(rdRow(4'h0, 3'd3, 1'b1, 32'h8000_0000));
    tbl.push_back(wrRow(3'd4, 32'h0, 1'b0, 32'h0));
    tbl.push_back(rdRow(4'h0, 3'd1, 1'b0, 32'h0));
    tbl.push_back(rdRow(4'h0, 3'd3, 1'b0, 32'h0));
    tbl.push_back(wrRow(3'd2, 32'hF, 1'b0, 32'h1));
    tbl.push_back(rdRow(4'h4, 3'd0, 1'b0, 32'h0));
    tbl.push_back(rdRow(4'h0, 3'd0, 1'b0, 32'h0));
    tbl.push_back(rdRow(4'h0, 3'd0, 1'b1, 32'h4));
    tbl.push_back(rdRow(4'h0, 3'd3, 1'b1, 32'h8000_0002));
    tbl.push_back(rdRow(4'h0, 3'd1, 1'b1, 32'h4));
    tbl.push_back(wrRow(3'd4, 32'h1, 1'b1, 32'h0));
    tbl.push_back(rdRow(4'h0, 3'd3, 1'b1, 32'h8000_0002));
    tbl.push_back(wrRow(3'd1, 32'h4, 1'b0, 32'h4));
    tbl.push_back(rdRow(4'h0, 3'd3, 1'b0, 32'h2));
    tbl.push_back(rdRow(4'h0, 3'd1, 1'b0, 32'h0));
    tbl.push_back(rdRow(4'h4, 3'd0, 1'b0, 32'h0));
    tbl.push_back(rdRow(4'h0, 3'd0, 1'b0, 32'h0));
    tbl.push_back(rdRow(4'h0, 3'd0, 1'b1, 32'h4));
    tbl.push_back(wrRow(3'd4, 32'h2, 1'b0, 32'h0));
    tbl.push_back(rdRow(4'h0, 3'd1, 1'b0, 32'h0));

    foreach (tbl[r]) begin
      applyStimulus(tbl[r].irqIn, tbl[r].cs, tbl[r].wrN, tbl[r].addr, tbl[r].wdata);
      checkOutput($sformatf("tbl[%0d] irq", r), {31'h0, irq}, {31'h0, tbl[r].expIrq});
      checkOutput($sformatf("tbl[%0d] readdata", r), readdata, tbl[r].expRd);
    end

    // Simultaneous edges on sources 1 and 3: lowest index first, then 3.
    applyStimulus(4'b1010, 1'b0, 1'b1, 3'd3, 32'h0);
    idleCycle();
    checkOutput("dual irq still low", {31'h0, irq}, 32'h0);
    idleCycle();
    checkOutput("dual irq high", {31'h0, irq}, 32'h1);
    busRead(3'd3, rd);
    checkOutput("dual vector first", rd, 32'h8000_0001);
    busWrite(3'd4, 32'h1);
    checkOutput("dual irq after ack", {31'h0, irq}, 32'h0);
    waitIrqHigh(8, n);
    checkOutput("dual rearm gap", 32'(n), COALESCE ? 32'd2 : 32'd1);
    busRead(3'd3, rd);
    checkOutput("dual vector second", rd, 32'h8000_0003);
    busWrite(3'd4, 32'h3);
    repeat (3) idleCycle();

    // Holdoff gap between two pending sources.
    busWrite(3'd5, 32'd10);
    busRead(3'd5, rd);
    checkOutput("holdoff readback", rd, COALESCE ? 32'd10 : 32'd0);
    applyStimulus(4'b0011, 1'b0, 1'b1, 3'd0, 32'h0);
    waitIrqHigh(6, n);
    checkOutput("holdoff first irq", {31'h0, irq}, 32'h1);
    busWrite(3'd4, 32'h0);
    n = 0;
    while (irq === 1'b0 && n < 50) begin
      n++;
      idleCycle();
    end
    checkOutput("holdoff low cycles", 32'(n), COALESCE ? 32'd11 : 32'd1);
    busRead(3'd3, rd);
    checkOutput("holdoff second vector", rd, 32'h8000_0001);
    busWrite(3'd4, 32'h1);
    repeat (14) idleCycle();

    // Reset in the middle of ASSERT, then a fresh edge after release.
    applyStimulus(4'b1000, 1'b0, 1'b1, 3'd1, 32'h0);
    idleCycle();
    idleCycle();
    checkOutput("pre-reset irq", {31'h0, irq}, 32'h1);
    applyStimulus(4'h0, 1'b0, 1'b1, 3'd1, 32'h0);
    checkOutput("pre-reset pending", readdata, 32'h8);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid-reset irq", {31'h0, irq}, 32'h0);
    checkOutput("mid-reset readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    busRead(3'd1, rd);
    checkOutput("post-reset pending", rd, 32'h0);
    busRead(3'd2, rd);
    checkOutput("post-reset mask", rd, 32'h0);
    busWrite(3'd2, 32'hF);
    applyStimulus(4'b0001, 1'b0, 1'b1, 3'd0, 32'h0);
    idleCycle();
    checkOutput("post-reset irq at 2", {31'h0, irq}, 32'h0);
    idleCycle();
    checkOutput("post-reset irq at 3", {31'h0, irq}, 32'h1);

    // Random traffic against the model, starting from a clean reset.
    applyStimulus(4'h0, 1'b0, 1'b1, 3'd0, 32'h0);
    #2 reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
    irqR = 4'h0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) irqR = irqR ^ 4'($urandom);
      rCs = 1'b0; rWrN = 1'b1; rA = 3'($urandom_range(0, 7)); rD = 32'h0;
      case ($urandom_range(0, 9))
        0: begin rCs = 1'b1; rWrN = 1'b0; rA = 3'd2; rD = $urandom; end
        1: begin rCs = 1'b1; rWrN = 1'b0; rA = 3'd1; rD = 32'h1 << $urandom_range(0, 3); end
        2, 3: begin
          rCs = 1'b1; rWrN = 1'b0; rA = 3'd4;
          rD = ($urandom & 32'hFFFF_FFF8) |
               (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : 32'(mIdx));
        end
        4: begin rCs = 1'b1; rWrN = 1'b0; rA = 3'd5; rD = 32'($urandom_range(0, 4)); end
        5: rCs = 1'b1;
        6: begin rWrN = 1'b0; rD = $urandom; end
        default: ;
      endcase
      modelStep(irqR, rCs, rWrN, rA, rD, eIrq, eRd);
      applyStimulus(irqR, rCs, rWrN, rA, rD);
      checkOutput($sformatf("rnd[%0d] irq", c), {31'h0, irq}, {31'h0, eIrq});
      checkOutput($sformatf("rnd[%0d] readdata a=%0d", c, rA), readdata, eRd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
